axi4_lite_master_amci: RTL and testbench
========================================

Name: axi4_lite_master_amci

Overview:
- AXI4-Lite master that pairs with our AXI4-Lite slave blocks and their ASHI handler interface.
- Fabric logic issues single register reads and writes through a simple AMCI command interface: address, data and a start pulse in; response, data and idle flag out.
- The block runs the AW/W/B and AR/R handshakes on M_AXI_*.
- Read and write engines are independent and may be in flight at the same time.

Parameters:
- AW, 32: AXI address width.
- DW, 32: AXI data width. Only 32 is supported.

Ports:
- axi_clk  in  1  sole clock.
- axi_reset  in  1  asynchronous, active-high reset.
- amci_waddr  in  AW  write address, sampled on amci_write.
- amci_wdata  in  DW  write data, sampled on amci_write.
- amci_write  in  1  single-cycle write start.
- amci_wresp  out  2  BRESP of the last completed write.
- amci_widle  out  1  1 = write engine idle.
- amci_raddr  in  AW  read address, sampled on amci_read.
- amci_read  in  1  single-cycle read start.
- amci_rdata  out  DW  RDATA of the last completed read.
- amci_rresp  out  2  RRESP of the last completed read.
- amci_ridle  out  1  1 = read engine idle.
- M_AXI_AWADDR out AW; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1; M_AXI_AWPROT out 3.
- M_AXI_WDATA out DW; M_AXI_WSTRB out 4; M_AXI_WVALID out 1; M_AXI_WREADY in 1.
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.
- M_AXI_ARADDR out AW; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1; M_AXI_ARPROT out 3.
- M_AXI_RDATA in DW; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Behaviour:
- Reset: applies asynchronously and clears all registers.
  - All VALID/READY outputs are 0; states are IDLE.
  - amci_wresp = amci_rresp = 0 (OKAY); amci_rdata = 0; AWADDR/ARADDR/WDATA = 0.
- Constant outputs: AWPROT = ARPROT = 0; WSTRB = 4'hF.
- Reset mid-transaction: the transaction is abandoned. No residual VALID/READY is driven after reset releases.
- Idle flags:
  - amci_widle = (wstate == W_IDLE) && !amci_write.
  - amci_ridle = (rstate == R_IDLE) && !amci_read.
  - Both flags are combinational, so each drops in the same cycle as its start pulse.
- A start pulse arriving while its engine is not in IDLE is ignored. The requester must wait for the idle flag.
- Write FSM:
  - W_IDLE: on amci_write, latch the address into AWADDR and the data into WDATA. Set AWVALID = WVALID = 1 on the next edge (latency 1). Go to W_AW_W.
  - W_AW_W: track the AW and W handshakes independently.
    - AWVALID clears on the cycle AWVALID && AWREADY occurs; WVALID clears on WVALID && WREADY.
    - A slave may accept either one first, or both in the same cycle.
    - When both handshakes are done, including the case where the final one occurs this cycle, set BREADY = 1 and go to W_B.
  - W_B: on BVALID && BREADY, register BRESP into amci_wresp, clear BREADY, go to W_IDLE.
  - Minimum write time with a zero-wait slave: 3 cycles from amci_write to amci_widle = 1.
- Read FSM:
  - R_IDLE: on amci_read, latch the address into ARADDR and set ARVALID on the next edge. Go to R_AR.
  - R_AR: on ARVALID && ARREADY, clear ARVALID, set RREADY, go to R_R.
  - R_R: on RVALID && RREADY, register RDATA/RRESP into amci_rdata/amci_rresp, clear RREADY, go to R_IDLE.
- VALID stability: once asserted, VALID is never withdrawn before its handshake. AWADDR, WDATA and ARADDR are held stable while their VALID is high.
- amci_wresp, amci_rresp and amci_rdata hold their values until the next completion of the same type.
  - The response is valid in the cycle the idle flag returns to 1.
- No timeout: a slave that never responds hangs that engine. The other engine is unaffected.
- Simultaneous amci_write and amci_read are both accepted in the same cycle.

Decomposition:
- Shared package, axi_lite_pkg:
  - response constants OKAY = 0, EXOKAY = 1, SLVERR = 2, DECERR = 3;
  - write state enum W_IDLE / W_AW_W / W_B;
  - read state enum R_IDLE / R_AR / R_R.
- No sub-module. Two always blocks, one per engine, inside a single module of about 200 lines.

Test Plan:
- Zero-wait slave: write 0x0000_0004 = 0x0000_0002 → AWVALID and WVALID high on cycle +1, BREADY on +2, amci_wresp = 0, amci_widle = 1 on cycle +3.
- Slave accepts W 5 cycles before AW: write 0x10 = 0xDEAD_BEEF → WVALID drops first, AWVALID is held with AWADDR = 0x10 stable, exactly one B handshake, amci_wresp = OKAY.
- Read 0x0 against a slave returning 0x0001_0003 / OKAY after 4 RVALID wait cycles → amci_rdata = 0x0001_0003, amci_rresp = 0, ARVALID high for exactly one handshake.
- Write to 0x7C answered with BRESP = DECERR → amci_wresp = 3; the next write, answered OKAY, → amci_wresp = 0.
- amci_write and amci_read pulsed in the same cycle, then amci_write re-pulsed while busy → both transactions complete, the second write pulse produces no AW/W activity, and both idle flags return to 1.
- axi_reset asserted while in W_B and R_AR → AWVALID, WVALID, BREADY, ARVALID and RREADY all 0 immediately (asynchronously); after release both idle flags = 1 and amci_rdata = 0.

Source files
------------

// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : axi_lite_pkg
// Purpose  : Shared AXI4-Lite response codes and master engine state types.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
package axi_lite_pkg;

   localparam logic [1:0] OKAY   = 2'd0;
   localparam logic [1:0] EXOKAY = 2'd1;
   localparam logic [1:0] SLVERR = 2'd2;
   localparam logic [1:0] DECERR = 2'd3;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_AW_W = 2'd1,
      W_B    = 2'd2
   } wstate_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_AR   = 2'd1,
      R_R    = 2'd2
   } rstate_t;

endpackage
`default_nettype wire

// File: rtl/axi4_lite_master_amci.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : axi4_lite_master_amci
// Purpose  : AXI4-Lite master with independent single-beat read/write engines.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module axi4_lite_master_amci
   import axi_lite_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
)(
   input  logic          axi_clk,
   input  logic          axi_reset,

   input  logic [AW-1:0] amci_waddr,
   input  logic [DW-1:0] amci_wdata,
   input  logic          amci_write,
   output logic [1:0]    amci_wresp,
   output logic          amci_widle,

   input  logic [AW-1:0] amci_raddr,
   input  logic          amci_read,
   output logic [DW-1:0] amci_rdata,
   output logic [1:0]    amci_rresp,
   output logic          amci_ridle,

   output logic [AW-1:0] M_AXI_AWADDR,
   output logic          M_AXI_AWVALID,
   input  logic          M_AXI_AWREADY,
   output logic [2:0]    M_AXI_AWPROT,

   output logic [DW-1:0] M_AXI_WDATA,
   output logic [3:0]    M_AXI_WSTRB,
   output logic          M_AXI_WVALID,
   input  logic          M_AXI_WREADY,

   input  logic [1:0]    M_AXI_BRESP,
   input  logic          M_AXI_BVALID,
   output logic          M_AXI_BREADY,

   output logic [AW-1:0] M_AXI_ARADDR,
   output logic          M_AXI_ARVALID,
   input  logic          M_AXI_ARREADY,
   output logic [2:0]    M_AXI_ARPROT,

   input  logic [DW-1:0] M_AXI_RDATA,
   input  logic [1:0]    M_AXI_RRESP,
   input  logic          M_AXI_RVALID,
   output logic          M_AXI_RREADY
);

   wstate_t       r_wstate;
   logic [AW-1:0] r_awaddr;
   logic [DW-1:0] r_wdata;
   logic          r_awvalid;
   logic          r_wvalid;
   logic          r_bready;
   logic [1:0]    r_wresp;

   rstate_t       r_rstate;
   logic [AW-1:0] r_araddr;
   logic          r_arvalid;
   logic          r_rready;
   logic [DW-1:0] r_rdata;
   logic [1:0]    r_rresp;

   // A channel counts as done if it finished earlier or handshakes this cycle.
   logic w_aw_done;
   logic w_w_done;
   assign w_aw_done = !r_awvalid || M_AXI_AWREADY;
   assign w_w_done  = !r_wvalid  || M_AXI_WREADY;

   always_ff @(posedge axi_clk or posedge axi_reset) begin
      if (axi_reset) begin
         r_wstate  <= W_IDLE;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
         r_wresp   <= OKAY;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (amci_write) begin
                  r_awaddr  <= amci_waddr;
                  r_wdata   <= amci_wdata;
                  r_awvalid <= 1'b1;
                  r_wvalid  <= 1'b1;
                  r_wstate  <= W_AW_W;
               end
            end
            W_AW_W: begin
               if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
               if (r_wvalid && M_AXI_WREADY)   r_wvalid  <= 1'b0;
               if (w_aw_done && w_w_done) begin
                  r_bready <= 1'b1;
                  r_wstate <= W_B;
               end
            end
            W_B: begin
               if (M_AXI_BVALID) begin
                  r_wresp  <= M_AXI_BRESP;
                  r_bready <= 1'b0;
                  r_wstate <= W_IDLE;
               end
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge axi_clk or posedge axi_reset) begin
      if (axi_reset) begin
         r_rstate  <= R_IDLE;
         r_araddr  <= '0;
         r_arvalid <= 1'b0;
         r_rready  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= OKAY;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (amci_read) begin
                  r_araddr  <= amci_raddr;
                  r_arvalid <= 1'b1;
                  r_rstate  <= R_AR;
               end
            end
            R_AR: begin
               if (M_AXI_ARREADY) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_rstate  <= R_R;
               end
            end
            R_R: begin
               if (M_AXI_RVALID) begin
                  r_rdata  <= M_AXI_RDATA;
                  r_rresp  <= M_AXI_RRESP;
                  r_rready <= 1'b0;
                  r_rstate <= R_IDLE;
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   // Idle flags fall combinationally with the start pulse.
   assign amci_widle    = (r_wstate == W_IDLE) && !amci_write;
   assign amci_ridle    = (r_rstate == R_IDLE) && !amci_read;
   assign amci_wresp    = r_wresp;
   assign amci_rdata    = r_rdata;
   assign amci_rresp    = r_rresp;

   assign M_AXI_AWADDR  = r_awaddr;
   assign M_AXI_AWVALID = r_awvalid;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_WDATA   = r_wdata;
   assign M_AXI_WSTRB   = 4'hF;
   assign M_AXI_WVALID  = r_wvalid;
   assign M_AXI_BREADY  = r_bready;
   assign M_AXI_ARADDR  = r_araddr;
   assign M_AXI_ARVALID = r_arvalid;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_RREADY  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_master_amci.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_axi4_lite_master_amci
// Purpose  : Randomised slave model with scoreboard for the AMCI AXI4-Lite master.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_axi4_lite_master_amci;
   import axi_lite_pkg::*;

   logic        axi_clk = 1'b0;
   logic        axi_reset;
   logic [31:0] amci_waddr, amci_wdata, amci_raddr;
   logic        amci_write, amci_read;
   logic [1:0]  amci_wresp, amci_rresp;
   logic        amci_widle, amci_ridle;
   logic [31:0] amci_rdata;
   logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
   logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic        M_AXI_RVALID, M_AXI_RREADY;
   logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
   logic [3:0]  M_AXI_WSTRB;
   logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;

   always #5 axi_clk = ~axi_clk;

   axi4_lite_master_amci #(.AW(32), .DW(32)) dut (
      .axi_clk(axi_clk), .axi_reset(axi_reset),
      .amci_waddr(amci_waddr), .amci_wdata(amci_wdata), .amci_write(amci_write),
      .amci_wresp(amci_wresp), .amci_widle(amci_widle),
      .amci_raddr(amci_raddr), .amci_read(amci_read), .amci_rdata(amci_rdata),
      .amci_rresp(amci_rresp), .amci_ridle(amci_ridle),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID),
      .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
      .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  resp;
   } txn_t;

   txn_t       slv_wq[$];
   txn_t       slv_rq[$];
   logic [1:0] sb_wq[$];
   txn_t       sb_rq[$];

   int tests  = 0;
   int errors = 0;

   // Slave latency knobs; a negative value means pick a random latency.
   int cfg_aw = -1, cfg_w = -1, cfg_b = -1, cfg_ar = -1, cfg_r = -1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      errors++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   function automatic int pick(input int cfg);
      if (cfg >= 0) return cfg;
      if ($urandom_range(0, 7) == 0) return int'($urandom_range(4, 8));
      return int'($urandom_range(0, 2));
   endfunction

   // Write-side slave: independent AW/W acceptance, then one B response.
   initial begin : slave_w
      int aw_cnt, w_cnt, b_cnt, aw_dly, w_dly, b_dly;
      bit got_aw, got_w, b_pend, pk_aw, pk_w;
      bit aw_hs, w_hs, b_hs, aw_wait, w_wait;
      logic [31:0] aw_hold, w_hold, cap_addr, cap_data;
      txn_t t;
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
      {aw_cnt, w_cnt, b_cnt, aw_dly, w_dly, b_dly} = '0;
      {got_aw, got_w, b_pend, pk_aw, pk_w, aw_wait, w_wait} = '0;
      cap_addr = 0; cap_data = 0; aw_hold = 0; w_hold = 0;
      forever begin
         @(negedge axi_clk);
         aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
         w_hs  = M_AXI_WVALID && M_AXI_WREADY;
         b_hs  = M_AXI_BVALID && M_AXI_BREADY;
         if (!axi_reset) begin
            if (aw_wait) check("aw_stable", {M_AXI_AWVALID, M_AXI_AWADDR}, {1'b1, aw_hold});
            if (w_wait)  check("w_stable", {M_AXI_WVALID, M_AXI_WDATA}, {1'b1, w_hold});
         end
         aw_wait = !axi_reset && M_AXI_AWVALID && !M_AXI_AWREADY;
         w_wait  = !axi_reset && M_AXI_WVALID && !M_AXI_WREADY;
         aw_hold = M_AXI_AWADDR;
         w_hold  = M_AXI_WDATA;
         if (aw_hs) cap_addr = M_AXI_AWADDR;
         if (w_hs)  cap_data = M_AXI_WDATA;
         @(posedge axi_clk); #1;
         if (axi_reset) begin
            {got_aw, got_w, b_pend, pk_aw, pk_w, aw_wait, w_wait} = '0;
            {aw_cnt, w_cnt, b_cnt} = '0;
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
            continue;
         end
         if (b_hs) begin
            M_AXI_BVALID = 0;
            {got_aw, got_w, b_pend, pk_aw, pk_w} = '0;
            {aw_cnt, w_cnt} = '0;
         end
         if (aw_hs) got_aw = 1;
         if (w_hs)  got_w  = 1;
         if (got_aw && got_w && !b_pend) begin
            if (slv_wq.size() == 0) begin
               fail_now("unexpected_write");
            end else begin
               t = slv_wq.pop_front();
               check("awaddr", cap_addr, t.addr);
               check("wdata", cap_data, t.data);
               M_AXI_BRESP = t.resp;
            end
            b_pend = 1; b_cnt = 0; b_dly = pick(cfg_b);
         end
         if (b_pend && !M_AXI_BVALID) begin
            if (b_cnt >= b_dly) M_AXI_BVALID = 1;
            else b_cnt++;
         end
         if (!got_aw && M_AXI_AWVALID) begin
            if (!pk_aw) begin aw_dly = pick(cfg_aw); pk_aw = 1; aw_cnt = 0; end
            else aw_cnt++;
         end
         if (!got_w && M_AXI_WVALID) begin
            if (!pk_w) begin w_dly = pick(cfg_w); pk_w = 1; w_cnt = 0; end
            else w_cnt++;
         end
         M_AXI_AWREADY = !got_aw && pk_aw && (aw_cnt >= aw_dly);
         M_AXI_WREADY  = !got_w && pk_w && (w_cnt >= w_dly);
      end
   end

   // Read-side slave: accept AR after a delay, return the queued data later.
   initial begin : slave_r
      int ar_cnt, r_cnt, ar_dly, r_dly;
      bit got_ar, pk_ar, ar_hs, r_hs, ar_wait;
      logic [31:0] ar_hold, cap_addr;
      txn_t t;
      M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
      {ar_cnt, r_cnt, ar_dly, r_dly} = '0;
      {got_ar, pk_ar, ar_wait} = '0;
      ar_hold = 0; cap_addr = 0;
      forever begin
         @(negedge axi_clk);
         ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
         r_hs  = M_AXI_RVALID && M_AXI_RREADY;
         if (!axi_reset && ar_wait)
            check("ar_stable", {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, ar_hold});
         ar_wait = !axi_reset && M_AXI_ARVALID && !M_AXI_ARREADY;
         ar_hold = M_AXI_ARADDR;
         if (ar_hs) cap_addr = M_AXI_ARADDR;
         @(posedge axi_clk); #1;
         if (axi_reset) begin
            {got_ar, pk_ar, ar_wait} = '0;
            {ar_cnt, r_cnt} = '0;
            M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
            continue;
         end
         if (r_hs) begin
            M_AXI_RVALID = 0;
            {got_ar, pk_ar} = '0;
            ar_cnt = 0;
         end
         if (ar_hs) begin
            got_ar = 1;
            if (slv_rq.size() == 0) begin
               fail_now("unexpected_read");
            end else begin
               t = slv_rq.pop_front();
               check("araddr", cap_addr, t.addr);
               M_AXI_RDATA = t.data;
               M_AXI_RRESP = t.resp;
            end
            r_cnt = 0; r_dly = pick(cfg_r);
         end
         if (got_ar && !M_AXI_RVALID) begin
            if (r_cnt >= r_dly) M_AXI_RVALID = 1;
            else r_cnt++;
         end
         if (!got_ar && M_AXI_ARVALID) begin
            if (!pk_ar) begin ar_dly = pick(cfg_ar); pk_ar = 1; ar_cnt = 0; end
            else ar_cnt++;
         end
         M_AXI_ARREADY = !got_ar && pk_ar && (ar_cnt >= ar_dly);
      end
   end

   // Monitor: one cycle after each B/R handshake the AMCI result must be visible.
   initial begin : monitor
      bit pw, pr;
      logic [1:0] ew;
      txn_t er;
      pw = 0; pr = 0;
      forever begin
         @(negedge axi_clk);
         if (axi_reset) begin
            pw = 0; pr = 0;
         end else begin
            if (pw) begin
               if (sb_wq.size() == 0) fail_now("wresp_no_expectation");
               else begin
                  ew = sb_wq.pop_front();
                  check("amci_wresp", amci_wresp, ew);
                  check("widle_after_b", amci_widle, 1);
               end
            end
            if (pr) begin
               if (sb_rq.size() == 0) fail_now("rdata_no_expectation");
               else begin
                  er = sb_rq.pop_front();
                  check("amci_rdata", amci_rdata, er.data);
                  check("amci_rresp", amci_rresp, er.resp);
                  check("ridle_after_r", amci_ridle, 1);
               end
            end
            pw = M_AXI_BVALID && M_AXI_BREADY;
            pr = M_AXI_RVALID && M_AXI_RREADY;
         end
      end
   end

   task automatic wait_widle();
      int n = 0;
      @(negedge axi_clk);
      while (!amci_widle && n < 400) begin @(negedge axi_clk); n++; end
      if (!amci_widle) fail_now("widle_timeout");
   endtask

   task automatic wait_ridle();
      int n = 0;
      @(negedge axi_clk);
      while (!amci_ridle && n < 400) begin @(negedge axi_clk); n++; end
      if (!amci_ridle) fail_now("ridle_timeout");
   endtask

   task automatic push_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
      txn_t t;
      t.addr = a; t.data = d; t.resp = r;
      slv_wq.push_back(t);
      sb_wq.push_back(r);
   endtask

   task automatic push_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
      txn_t t;
      t.addr = a; t.data = d; t.resp = r;
      slv_rq.push_back(t);
      sb_rq.push_back(t);
   endtask

   // Issue one write; optionally re-pulse while busy, which must be ignored.
   task automatic issue_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r,
                              input bit repulse);
      @(posedge axi_clk); #1;
      amci_waddr = a; amci_wdata = d; amci_write = 1;
      push_write(a, d, r);
      @(posedge axi_clk); #1;
      if (repulse) begin
         amci_waddr = ~a; amci_wdata = ~d;
         @(posedge axi_clk); #1;
      end
      amci_write = 0;
   endtask

   task automatic issue_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r,
                             input bit repulse);
      @(posedge axi_clk); #1;
      amci_raddr = a; amci_read = 1;
      push_read(a, d, r);
      @(posedge axi_clk); #1;
      if (repulse) begin
         amci_raddr = ~a;
         @(posedge axi_clk); #1;
      end
      amci_read = 0;
   endtask

   initial begin : stimulus
      int n;
      amci_waddr = 0; amci_wdata = 0; amci_write = 0;
      amci_raddr = 0; amci_read = 0;
      axi_reset = 1;
      repeat (3) @(posedge axi_clk);
      @(negedge axi_clk);
      check("rst_handshake_outs",
            {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
      check("rst_amci_outs", {amci_wresp, amci_rresp, amci_rdata}, 0);
      check("rst_addr_data", {M_AXI_AWADDR, M_AXI_ARADDR}, 0);
      check("rst_wdata", M_AXI_WDATA, 0);
      check("const_outs", {M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB}, 10'h00F);
      axi_reset = 0;
      check("rst_idle", {amci_widle, amci_ridle}, 2'b11);

      // Zero-wait slave write latency.
      cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_ar = 0; cfg_r = 0;
      repeat (2) @(negedge axi_clk);
      @(posedge axi_clk); #1;
      amci_waddr = 32'h4; amci_wdata = 32'h2; amci_write = 1;
      push_write(32'h4, 32'h2, OKAY);
      @(posedge axi_clk); #1;
      amci_write = 0;
      @(negedge axi_clk);
      check("zw_cycle1", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, amci_widle}, 4'b1100);
      @(negedge axi_clk);
      check("zw_cycle2", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, amci_widle}, 4'b0010);
      @(negedge axi_clk);
      check("zw_cycle3", {amci_widle, amci_wresp}, 3'b100);

      // W accepted five cycles before AW.
      cfg_aw = 5; cfg_w = 0;
      wait_widle();
      @(posedge axi_clk); #1;
      amci_waddr = 32'h10; amci_wdata = 32'hDEAD_BEEF; amci_write = 1;
      push_write(32'h10, 32'hDEAD_BEEF, OKAY);
      @(posedge axi_clk); #1;
      amci_write = 0;
      @(posedge axi_clk);
      @(negedge axi_clk);
      check("w_first", {M_AXI_WVALID, M_AXI_AWVALID, M_AXI_AWADDR}, {2'b01, 32'h10});
      wait_widle();

      // Read with four RVALID wait cycles; DECERR then OKAY writes.
      cfg_aw = 0; cfg_r = 4;
      wait_ridle();
      issue_read(32'h0, 32'h0001_0003, OKAY, 0);
      wait_ridle();
      cfg_r = 0;
      issue_write(32'h7C, 32'h1234_5678, DECERR, 0);
      wait_widle();
      issue_write(32'h7C, 32'h8765_4321, OKAY, 0);
      wait_widle();

      // Simultaneous start, write re-pulsed while busy.
      @(posedge axi_clk); #1;
      amci_waddr = 32'h20; amci_wdata = 32'hA5A5_0001; amci_write = 1;
      amci_raddr = 32'h24; amci_read = 1;
      push_write(32'h20, 32'hA5A5_0001, SLVERR);
      push_read(32'h24, 32'h5A5A_0002, EXOKAY);
      @(posedge axi_clk); #1;
      amci_read = 0; amci_waddr = 32'h30; amci_wdata = 32'hFFFF_FFFF;
      @(posedge axi_clk); #1;
      amci_write = 0;
      wait_widle();
      wait_ridle();

      // Randomised traffic on both engines concurrently.
      cfg_aw = -1; cfg_w = -1; cfg_b = -1; cfg_ar = -1; cfg_r = -1;
      fork
         for (int i = 0; i < 30; i++) begin
            wait_widle();
            issue_write($urandom & 32'hFFFF_FFFC, $urandom, 2'($urandom_range(0, 3)),
                        $urandom_range(0, 3) == 0);
         end
         for (int j = 0; j < 30; j++) begin
            wait_ridle();
            issue_read($urandom & 32'hFFFF_FFFC, $urandom, 2'($urandom_range(0, 3)),
                       $urandom_range(0, 3) == 0);
         end
      join
      wait_widle();
      wait_ridle();
      repeat (2) @(negedge axi_clk);
      check("queues_drained", sb_wq.size() + sb_rq.size() + slv_wq.size() + slv_rq.size(), 0);

      // Reset while the write waits in W_B and the read waits in R_AR.
      cfg_aw = 0; cfg_w = 0; cfg_b = 40; cfg_ar = 40; cfg_r = 0;
      @(posedge axi_clk); #1;
      amci_waddr = 32'h40; amci_wdata = 32'h1; amci_write = 1;
      amci_raddr = 32'h44; amci_read = 1;
      push_write(32'h40, 32'h1, OKAY);
      push_read(32'h44, 32'h2, OKAY);
      @(posedge axi_clk); #1;
      amci_write = 0; amci_read = 0;
      n = 0;
      @(negedge axi_clk);
      while (!M_AXI_BREADY && n < 20) begin @(negedge axi_clk); n++; end
      check("pre_rst_state", {M_AXI_BREADY, M_AXI_ARVALID}, 2'b11);
      #2 axi_reset = 1;
      #1;
      check("async_rst_outs",
            {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
      repeat (2) @(negedge axi_clk);
      slv_wq.delete(); slv_rq.delete(); sb_wq.delete(); sb_rq.delete();
      axi_reset = 0;
      @(negedge axi_clk);
      check("post_rst_idle", {amci_widle, amci_ridle}, 2'b11);
      check("post_rst_rdata", {amci_rdata, amci_wresp, amci_rresp}, 0);
      check("post_rst_valids",
            {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);

      // Recovery after reset.
      cfg_b = 0; cfg_ar = 0;
      issue_write(32'h50, 32'hCAFE_F00D, OKAY, 0);
      issue_read(32'h54, 32'hBEEF_0000, SLVERR, 0);
      wait_widle();
      wait_ridle();
      repeat (2) @(negedge axi_clk);
      check("final_drained", sb_wq.size() + sb_rq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
